next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
//   Parametrised program-counter generator for the RV32I fetch stage. Holds the PC
//   register, presents it to instruction fetch over a valid/ready handshake and
//   advances it by IALIGN-sized steps. Resolves branch/JAL/JALR redirects (base + imm)
//   from execute and raises a misaligned-target trap. Replaces the bare pc+imm adder.
// PARAMETERS
//   XLEN          32            address/PC width in bits
//   RESET_VECTOR  32'h0000_0000 PC value loaded by reset
//   TRAP_VECTOR   32'h0000_0100 PC loaded after a misalignment trap is acknowledged
//   IALIGN        4             instruction alignment and sequential step in bytes (4 or 2)
// PORTS
//   clk             in   1     clock, all state updates on rising edge
//   rst_n           in   1     reset, synchronous, active-low
//   fetch_valid     out  1     fetch_pc is a valid fetch request
//   fetch_ready     in   1     fetch stage accepts fetch_pc this cycle
//   fetch_pc        out  XLEN  current PC
//   stall           in   1     hazard stall from pipeline control
//   redirect_valid  in   1     execute presents a control-transfer instruction
//   redirect_kind   in   2     00 branch, 01 JAL, 10 JALR, 11 reserved (ignored)
//   branch_taken    in   1     branch condition result; only used when kind=00
//   redirect_base   in   XLEN  PC of the branch/JAL, or rs1 value for JALR
//   redirect_imm    in   XLEN  sign-extended immediate
//   misalign_trap   out  1     misaligned control-transfer target detected
//   misalign_addr   out  XLEN  offending target address
//   trap_ack        in   1     trap handler acknowledges misalign_trap
// BEHAVIOUR
//   Reset (rst_n=0 at a rising edge): fetch_pc=RESET_VECTOR, state=BOOT,
//     fetch_valid=0, misalign_trap=0, misalign_addr=0. Reset overrides all inputs,
//     including mid-trap or mid-redirect.
//   States: BOOT, RUN, TRAP.
//     BOOT -> RUN unconditionally after one cycle; fetch_valid=0 in BOOT.
//     RUN: fetch_valid = !stall. TRAP: fetch_valid=0, misalign_trap=1.
//   Target arithmetic: target = (redirect_base + redirect_imm) mod 2^XLEN, carry dropped;
//     JALR clears target bit 0 before the alignment check.
//   Redirect is "effective" when redirect_valid=1 and (kind=01 or kind=10 or
//     (kind=00 and branch_taken=1)). Not-taken branch and kind=11: no effect.
//   Next-PC priority in RUN (evaluated each rising edge):
//     1. effective redirect, target % IALIGN != 0: fetch_pc held, state->TRAP,
//        misalign_addr=target.
//     2. effective redirect, aligned: fetch_pc=target (flush; legal even while
//        fetch_valid=1 and fetch_ready=0, and accepted while stall=1).
//     3. fetch_valid & fetch_ready: fetch_pc=fetch_pc+IALIGN (wraps to 0 at top).
//     4. otherwise fetch_pc held.
//   Handshake: while fetch_valid=1 and fetch_ready=0, fetch_pc stays stable except
//     for case 1/2. A redirect updates fetch_pc one cycle after it is presented.
//   stall=1 forces fetch_valid=0 combinationally; no sequential advance occurs.
//   TRAP: redirects and stall ignored; on trap_ack=1 -> fetch_pc=TRAP_VECTOR,
//     misalign_trap=0, state->RUN. misalign_addr holds until the next trap.
//   Simultaneous redirect and accepted fetch: redirect wins, accepted PC is dropped.
//   IALIGN=2: step is +2, only bit 0 checked for alignment.
// TESTING
//   Reset, fetch_ready=1 constant -> BOOT 1 cycle, then fetch_pc 0x0,0x4,0x8,0xC.
//   fetch_ready=0 for 3 cycles at PC 0x8 -> fetch_pc stays 0x8, fetch_valid=1.
//   JAL base=0x10 imm=0x20 -> next fetch_pc 0x30; branch not-taken same values -> 0x14.
//   JALR base=0x103 imm=0x4 -> next fetch_pc 0x106 with IALIGN=2; with IALIGN=4 ->
//     misalign_trap=1, misalign_addr=0x106, fetch_valid=0; trap_ack -> fetch_pc 0x100.
//   fetch_pc=0xFFFF_FFFC accepted -> wraps to 0x0; base=0xFFFF_FFF0 imm=0x20 -> 0x10.
//   rst_n=0 while in TRAP with trap_ack=1 -> fetch_pc=RESET_VECTOR, misalign_trap=0.

Source files
------------

// File: rtl/next_pc_unit.sv
// Program-counter generator for the RV32I fetch stage: sequential stepping over a
// valid/ready fetch handshake, execute-stage redirects and misaligned-target trapping.
module next_pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              IALIGN       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_kind,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_imm,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr,
  input  logic            trap_ack
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [XLEN-1:0] target;
  logic            effective;
  logic            misaligned;

  // JALR drops target bit 0 before the alignment test; carry out of the add is lost.
  always_comb begin
    target = redirect_base + redirect_imm;
    if (redirect_kind == 2'b10) target[0] = 1'b0;
    effective = redirect_valid &&
                ((redirect_kind == 2'b01) || (redirect_kind == 2'b10) ||
                 ((redirect_kind == 2'b00) && branch_taken));
    misaligned = (target & ALIGN_MASK) != '0;
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    addr_next     = addr_reg;
    fetch_valid   = 1'b0;
    misalign_trap = 1'b0;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        fetch_valid = !stall;
        // Redirect outranks an accepted fetch; the accepted PC is simply dropped.
        if (effective && misaligned) begin
          state_next = TRAP;
          addr_next  = target;
        end else if (effective) begin
          pc_next = target;
        end else if (!stall && fetch_ready) begin
          pc_next = pc_reg + STEP;
        end
      end
      TRAP: begin
        misalign_trap = 1'b1;
        if (trap_ack) begin
          pc_next    = TRAP_VECTOR;
          state_next = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_VECTOR;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      addr_reg  <= addr_next;
    end
  end

  assign fetch_pc      = pc_reg;
  assign misalign_addr = addr_reg;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: one instance with 4-byte and one with 2-byte alignment,
// driven by identical stimulus and checked every cycle against a behavioural model.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ready;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic        branch_taken;
  logic [31:0] redirect_base;
  logic [31:0] redirect_imm;
  logic        trap_ack;

  logic        fv4, fv2, tr4, tr2;
  logic [31:0] pc4, pc2, ad4, ad2;

  int n_vec = 0;
  int n_err = 0;

  // Model state: index 0 mirrors the IALIGN=4 instance, index 1 the IALIGN=2 one.
  int          m_state [2];   // 0 booting, 1 running, 2 trapped
  logic [31:0] m_pc    [2];
  logic [31:0] m_addr  [2];
  int          m_align [2] = '{4, 2};

  always #5 clk = ~clk;

  next_pc_unit #(.IALIGN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fv4), .fetch_ready(fetch_ready),
    .fetch_pc(pc4), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_kind(redirect_kind), .branch_taken(branch_taken),
    .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .misalign_trap(tr4), .misalign_addr(ad4), .trap_ack(trap_ack));

  next_pc_unit #(.IALIGN(2)) u2 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fv2), .fetch_ready(fetch_ready),
    .fetch_pc(pc2), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_kind(redirect_kind), .branch_taken(branch_taken),
    .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .misalign_trap(tr2), .misalign_addr(ad2), .trap_ack(trap_ack));

  function automatic logic [65:0] obs_vec(input int i);
    return (i == 0) ? {fv4, tr4, pc4, ad4} : {fv2, tr2, pc2, ad2};
  endfunction

  function automatic logic [65:0] exp_vec(input int i);
    logic v;
    v = (m_state[i] == 1) && !stall;
    return {v, m_state[i] == 2, m_pc[i], m_addr[i]};
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] t;
    bit          eff;
    for (int i = 0; i < 2; i++) begin
      t   = redirect_base + redirect_imm;
      if (redirect_kind == 2'd2) t = t & 32'hFFFF_FFFE;
      eff = redirect_valid && (redirect_kind == 2'd1 || redirect_kind == 2'd2 ||
                               (redirect_kind == 2'd0 && branch_taken));
      if (!rst_n) begin
        m_state[i] = 0; m_pc[i] = 32'h0; m_addr[i] = 32'h0;
      end else if (m_state[i] == 0) begin
        m_state[i] = 1;
      end else if (m_state[i] == 1) begin
        if (eff && (t % 32'(m_align[i])) != 0) begin
          m_state[i] = 2; m_addr[i] = t;
        end else if (eff) begin
          m_pc[i] = t;
        end else if (!stall && fetch_ready) begin
          m_pc[i] = m_pc[i] + 32'(m_align[i]);
        end
      end else if (trap_ack) begin
        m_state[i] = 1; m_pc[i] = 32'h100;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; redirect_valid = 0; redirect_kind = 2'd0; branch_taken = 0;
    redirect_base = 0; redirect_imm = 0; trap_ack = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; fetch_ready = 1; idle_inputs();
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs_vec(i) !== exp_vec(i)) begin
        n_err++;
        $display("FAIL reset inst%0d got %h expected %h", i, obs_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_sequential();
    rst_n = 1; fetch_ready = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (obs_vec(i) !== exp_vec(i)) begin
          n_err++;
          $display("FAIL sequential c%0d inst%0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
    end
    n_vec++;
    if (pc4 !== 32'h8) begin
      n_err++;
      $display("FAIL sequential_pc got %h expected %h", pc4, 32'h8);
    end
  endtask

  task automatic test_backpressure();
    fetch_ready = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (pc4 !== 32'h8 || fv4 !== 1'b1 || obs_vec(1) !== exp_vec(1)) begin
        n_err++;
        $display("FAIL backpressure c%0d got pc=%h valid=%b inst1=%h expected pc=8 valid=1 inst1=%h",
                 c, pc4, fv4, obs_vec(1), exp_vec(1));
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] want [3] = '{32'h30, 32'h10, 32'h14};
    fetch_ready = 1;
    for (int c = 0; c < 3; c++) begin
      redirect_valid = 1; branch_taken = 0;
      redirect_kind  = (c == 2) ? 2'd0 : 2'd1;
      redirect_base  = (c == 1) ? 32'h0 : 32'h10;
      redirect_imm   = (c == 1) ? 32'h10 : 32'h20;
      tick();
      n_vec++;
      if (pc4 !== want[c] || obs_vec(1) !== exp_vec(1)) begin
        n_err++;
        $display("FAIL redirect c%0d got pc=%h inst1=%h expected pc=%h inst1=%h",
                 c, pc4, obs_vec(1), want[c], exp_vec(1));
      end
    end
    idle_inputs();
  endtask

  task automatic test_jalr_trap();
    redirect_valid = 1; redirect_kind = 2'd2; redirect_base = 32'h103; redirect_imm = 32'h4;
    tick();
    n_vec++;
    if (tr4 !== 1'b1 || ad4 !== 32'h106 || fv4 !== 1'b0 || pc2 !== 32'h106) begin
      n_err++;
      $display("FAIL jalr_trap got trap=%b addr=%h valid=%b pc2=%h expected 1 106 0 106",
               tr4, ad4, fv4, pc2);
    end
    // Inside TRAP, redirects and stall must be ignored by the 4-byte instance.
    redirect_kind = 2'd1; redirect_base = 32'h200; redirect_imm = 32'h0; stall = 1;
    tick();
    idle_inputs(); trap_ack = 1;
    tick();
    trap_ack = 0;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs_vec(i) !== exp_vec(i)) begin
        n_err++;
        $display("FAIL trap_ack inst%0d got %h expected %h", i, obs_vec(i), exp_vec(i));
      end
    end
    n_vec++;
    if (pc4 !== 32'h100 || tr4 !== 1'b0) begin
      n_err++;
      $display("FAIL trap_vector got pc=%h trap=%b expected 100 0", pc4, tr4);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_kind = 2'd1; redirect_base = 32'hFFFF_FFF0; redirect_imm = 32'hC;
    tick();
    redirect_valid = 0; fetch_ready = 1;
    tick();
    n_vec++;
    if (pc4 !== 32'h0 || obs_vec(1) !== exp_vec(1)) begin
      n_err++;
      $display("FAIL wrap_step got pc=%h inst1=%h expected 0 inst1=%h", pc4, obs_vec(1), exp_vec(1));
    end
    redirect_valid = 1; redirect_imm = 32'h20;
    tick();
    idle_inputs();
    n_vec++;
    if (pc4 !== 32'h10 || pc2 !== 32'h10) begin
      n_err++;
      $display("FAIL wrap_target got pc4=%h pc2=%h expected 10 10", pc4, pc2);
    end
  endtask

  task automatic test_reset_in_trap();
    redirect_valid = 1; redirect_kind = 2'd2; redirect_base = 32'h103; redirect_imm = 32'h4;
    tick();
    idle_inputs(); rst_n = 0; trap_ack = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs_vec(i) !== exp_vec(i) || obs_vec(i) !== 66'h0) begin
        n_err++;
        $display("FAIL reset_in_trap inst%0d got %h expected %h", i, obs_vec(i), exp_vec(i));
      end
    end
    rst_n = 1; trap_ack = 0;
  endtask

  task automatic test_back_to_back();
    fetch_ready = 1;
    for (int c = 0; c < 6; c++) begin
      redirect_valid = 1; redirect_kind = 2'(c % 3); branch_taken = c[0];
      redirect_base = 32'h40 * (c + 1); redirect_imm = 32'(c * 2);
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (obs_vec(i) !== exp_vec(i)) begin
          n_err++;
          $display("FAIL back_to_back c%0d inst%0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
      if (m_state[0] == 2) begin
        redirect_valid = 0; trap_ack = 1;
        tick();
        trap_ack = 0;
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n          = ($urandom % 60) != 0;
      fetch_ready    = ($urandom % 4) != 0;
      stall          = ($urandom % 5) == 0;
      redirect_valid = ($urandom % 4) == 0;
      redirect_kind  = 2'($urandom);
      branch_taken   = 1'($urandom);
      redirect_base  = (($urandom % 4) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      redirect_imm   = (($urandom % 4) == 0) ? $urandom : 32'($urandom_range(0, 128)) - 32'd64;
      trap_ack       = ($urandom % 3) == 0;
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (obs_vec(i) !== exp_vec(i)) begin
          n_err++;
          $display("FAIL random c%0d inst%0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_jalr_trap();
    test_wrap();
    test_reset_in_trap();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
